// File: rtl/dec1_fwd_stage.sv
// dec1_fwd_stage: operand forwarding/qualification with valid/ready handshake, load-use stall, flush and stall counter
module dec1_fwd_stage #(
  parameter int XLEN        = 32,
  parameter int NB_FF       = 3,
  parameter int CTRL_W      = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [XLEN-1:0]          pc_i,
  input  logic                     rd_v_i,
  input  logic [4:0]               rd_adr_i,
  input  logic                     rs1_v_i,
  input  logic [4:0]               rs1_adr_i,
  input  logic [XLEN-1:0]          rs1_data_i,
  input  logic                     rs2_v_i,
  input  logic [4:0]               rs2_adr_i,
  input  logic [XLEN-1:0]          rs2_data_i,
  input  logic                     rs1_is_imm_i,
  input  logic                     rs2_is_imm_i,
  input  logic                     auipc_i,
  input  logic [XLEN-1:0]          imm_i,
  input  logic                     unsign_i,
  input  logic                     clear_i,
  input  logic                     ca2_i,
  input  logic [CTRL_W-1:0]        ctrl_i,
  input  logic [NB_FF-1:0]         ff_v_i,
  input  logic [5*NB_FF-1:0]       ff_adr_i,
  input  logic [NB_FF-1:0]         ff_rdy_i,
  input  logic [XLEN*NB_FF-1:0]    ff_data_i,
  input  logic                     flush_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [XLEN-1:0]          pc_o,
  output logic                     rd_v_o,
  output logic [4:0]               rd_adr_o,
  output logic [XLEN:0]            rs1_q_o,
  output logic [XLEN:0]            rs2_q_o,
  output logic [XLEN-1:0]          imm_o,
  output logic [CTRL_W-1:0]        ctrl_o,
  output logic [STALL_CNT_W-1:0]   stall_cnt_o
);
  logic [XLEN-1:0]        sel1, sel2, op1, op2;
  logic [XLEN:0]          e2, rs1_d, rs2_d;
  logic                   hz1, hz2, hz, adv, accept;
  logic                   out_valid_q, rd_v_q;
  logic [XLEN-1:0]        pc_q, imm_q;
  logic [4:0]             rd_adr_q;
  logic [XLEN:0]          rs1_q, rs2_q;
  logic [CTRL_W-1:0]      ctrl_q;
  logic [STALL_CNT_W-1:0] stall_q;
  // Scan from the oldest source down so the youngest matching source wins.
  always_comb begin
    sel1 = rs1_adr_i == 5'd0 ? '0 : rs1_data_i;
    sel2 = rs2_adr_i == 5'd0 ? '0 : rs2_data_i;
    hz1  = 1'b0;
    hz2  = 1'b0;
    for (int i = NB_FF - 1; i >= 0; i--) begin
      if (rs1_v_i && rs1_adr_i != 5'd0 && ff_v_i[i] && ff_adr_i[5*i +: 5] == rs1_adr_i) begin
        sel1 = ff_data_i[XLEN*i +: XLEN];
        hz1  = ~ff_rdy_i[i];
      end
      if (rs2_v_i && rs2_adr_i != 5'd0 && ff_v_i[i] && ff_adr_i[5*i +: 5] == rs2_adr_i) begin
        sel2 = ff_data_i[XLEN*i +: XLEN];
        hz2  = ~ff_rdy_i[i];
      end
    end
  end
  always_comb begin
    op1   = (rs1_v_i ? sel1 : '0) | (rs1_is_imm_i ? imm_i : '0) | (auipc_i ? pc_i : '0);
    op2   = (rs2_v_i ? sel2 : '0) | (rs2_is_imm_i ? imm_i : '0);
    rs1_d = {~unsign_i & op1[XLEN-1], clear_i ? ~op1 : op1};
    e2    = {~unsign_i & op2[XLEN-1], op2};
    rs2_d = ca2_i ? ~e2 + (XLEN+1)'(1) : e2;
  end
  assign hz         = hz1 | hz2;
  assign adv        = ~out_valid_q | out_ready_i;
  assign in_ready_o = flush_i | (adv & ~hz);
  assign accept     = in_valid_i & in_ready_o & ~flush_i;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      rd_v_q      <= 1'b0;
      rd_adr_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      ctrl_q      <= '0;
      stall_q     <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        pc_q        <= pc_i;
        rd_v_q      <= rd_v_i;
        rd_adr_q    <= rd_adr_i;
        rs1_q       <= rs1_d;
        rs2_q       <= rs2_d;
        imm_q       <= imm_i;
        ctrl_q      <= ctrl_i;
      end else if (out_ready_i | flush_i) begin
        out_valid_q <= 1'b0;
      end
      if (in_valid_i & hz & ~flush_i & adv & ~&stall_q)
        stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end
  assign out_valid_o = out_valid_q;
  assign pc_o        = pc_q;
  assign rd_v_o      = rd_v_q;
  assign rd_adr_o    = rd_adr_q;
  assign rs1_q_o     = rs1_q;
  assign rs2_q_o     = rs2_q;
  assign imm_o       = imm_q;
  assign ctrl_o      = ctrl_q;
  assign stall_cnt_o = stall_q;
endmodule

// File: tb/tb_dec1_fwd_stage.sv
// tb_dec1_fwd_stage: directed and random checks of dec1_fwd_stage against a behavioural model
module tb_dec1_fwd_stage;
  localparam int SW = 4;
  logic clk = 1'b0, reset;
  logic in_valid, in_ready, rd_v, rs1_v, rs2_v, rs1_is_imm, rs2_is_imm, auipc, unsign, clear, ca2, flush;
  logic out_valid, out_ready, rd_v_o;
  logic [31:0] pc, rs1_data, rs2_data, imm, ctrl, pc_o, imm_o, ctrl_o;
  logic [4:0]  rd_adr, rs1_adr, rs2_adr, rd_adr_o;
  logic [2:0]  ff_v, ff_rdy;
  logic [4:0]  ff_adr_a [3];
  logic [31:0] ff_data_a [3];
  logic [14:0] ff_adr;
  logic [95:0] ff_data;
  logic [32:0] rs1_q, rs2_q;
  logic [SW-1:0] stall_cnt;
  int n_chk = 0, n_fail = 0;
  logic last_rdy;
  logic m_valid = 1'b0, m_rdv = 1'b0;
  logic [31:0] m_pc = '0, m_imm = '0, m_ctrl = '0;
  logic [4:0]  m_rda = '0;
  logic [32:0] m_r1 = '0, m_r2 = '0;
  logic [SW-1:0] m_stall = '0;

  for (genvar g = 0; g < 3; g++) begin : g_pk
    assign ff_adr[5*g +: 5]   = ff_adr_a[g];
    assign ff_data[32*g +: 32] = ff_data_a[g];
  end

  always #5 clk = ~clk;

  dec1_fwd_stage #(.XLEN(32), .NB_FF(3), .CTRL_W(32), .STALL_CNT_W(SW)) dut (
    .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(in_ready), .pc_i(pc),
    .rd_v_i(rd_v), .rd_adr_i(rd_adr), .rs1_v_i(rs1_v), .rs1_adr_i(rs1_adr), .rs1_data_i(rs1_data),
    .rs2_v_i(rs2_v), .rs2_adr_i(rs2_adr), .rs2_data_i(rs2_data), .rs1_is_imm_i(rs1_is_imm),
    .rs2_is_imm_i(rs2_is_imm), .auipc_i(auipc), .imm_i(imm), .unsign_i(unsign), .clear_i(clear),
    .ca2_i(ca2), .ctrl_i(ctrl), .ff_v_i(ff_v), .ff_adr_i(ff_adr), .ff_rdy_i(ff_rdy),
    .ff_data_i(ff_data), .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .pc_o(pc_o), .rd_v_o(rd_v_o), .rd_adr_o(rd_adr_o), .rs1_q_o(rs1_q), .rs2_q_o(rs2_q),
    .imm_o(imm_o), .ctrl_o(ctrl_o), .stall_cnt_o(stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; in_valid = 1'b0; pc = '0; rd_v = 1'b0; rd_adr = '0;
    rs1_v = 1'b0; rs1_adr = '0; rs1_data = '0; rs2_v = 1'b0; rs2_adr = '0; rs2_data = '0;
    rs1_is_imm = 1'b0; rs2_is_imm = 1'b0; auipc = 1'b0; imm = '0; unsign = 1'b0;
    clear = 1'b0; ca2 = 1'b0; ctrl = '0; ff_v = '0; ff_rdy = '1; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin ff_adr_a[i] = '0; ff_data_a[i] = '0; end
  endtask

  task automatic rnd();
    reset = $urandom_range(0, 199) == 0; in_valid = $urandom_range(0, 3) != 0;
    pc = $urandom; rd_v = $urandom_range(0, 1) == 1; rd_adr = 5'($urandom_range(0, 31));
    rs1_v = $urandom_range(0, 3) != 0; rs1_adr = 5'($urandom_range(0, 3)); rs1_data = $urandom;
    rs2_v = $urandom_range(0, 3) != 0; rs2_adr = 5'($urandom_range(0, 3)); rs2_data = $urandom;
    rs1_is_imm = $urandom_range(0, 3) == 0; rs2_is_imm = $urandom_range(0, 3) == 0;
    auipc = $urandom_range(0, 5) == 0; imm = $urandom; unsign = $urandom_range(0, 1) == 1;
    clear = $urandom_range(0, 1) == 1; ca2 = $urandom_range(0, 1) == 1; ctrl = $urandom;
    flush = $urandom_range(0, 15) == 0; out_ready = $urandom_range(0, 3) != 0;
    for (int i = 0; i < 3; i++) begin
      ff_v[i] = $urandom_range(0, 1) == 1; ff_rdy[i] = $urandom_range(0, 3) != 0;
      ff_adr_a[i] = 5'($urandom_range(0, 3)); ff_data_a[i] = $urandom;
    end
  endtask

  // One clock of the reference model: youngest matching forward wins, x0 reads zero.
  task automatic step();
    int s1, s2;
    logic [31:0] v1, v2, o1, o2;
    logic [32:0] e1, e2, r1, r2;
    logic hz, adv, rdy, acc;
    #1;
    s1 = -1; s2 = -1;
    for (int i = 0; i < 3; i++) begin
      if (s1 < 0 && rs1_v && rs1_adr != 0 && ff_v[i] && ff_adr_a[i] == rs1_adr) s1 = i;
      if (s2 < 0 && rs2_v && rs2_adr != 0 && ff_v[i] && ff_adr_a[i] == rs2_adr) s2 = i;
    end
    v1 = rs1_adr == 0 ? 32'd0 : s1 >= 0 ? ff_data_a[s1] : rs1_data;
    v2 = rs2_adr == 0 ? 32'd0 : s2 >= 0 ? ff_data_a[s2] : rs2_data;
    hz = (s1 >= 0 && !ff_rdy[s1]) || (s2 >= 0 && !ff_rdy[s2]);
    o1 = (rs1_v ? v1 : 32'd0) | (rs1_is_imm ? imm : 32'd0) | (auipc ? pc : 32'd0);
    o2 = (rs2_v ? v2 : 32'd0) | (rs2_is_imm ? imm : 32'd0);
    e1 = {unsign ? 1'b0 : o1[31], o1};
    r1 = clear ? {e1[32], ~o1} : e1;
    e2 = {unsign ? 1'b0 : o2[31], o2};
    r2 = ca2 ? 33'd0 - e2 : e2;
    adv = !m_valid || out_ready;
    rdy = flush || (adv && !hz);
    acc = in_valid && rdy && !flush;
    last_rdy = in_ready;
    if (!reset) check("in_ready", in_ready, rdy);
    if (reset) begin
      m_valid = 0; m_rdv = 0; m_pc = 0; m_imm = 0; m_ctrl = 0; m_rda = 0; m_r1 = 0; m_r2 = 0; m_stall = 0;
    end else begin
      if (in_valid && hz && !flush && adv && m_stall != {SW{1'b1}}) m_stall = m_stall + 1;
      if (acc) begin
        m_valid = 1; m_pc = pc; m_rdv = rd_v; m_rda = rd_adr; m_r1 = r1; m_r2 = r2; m_imm = imm; m_ctrl = ctrl;
      end else if (out_ready || flush) m_valid = 0;
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_valid);
    check("stall_cnt", stall_cnt, m_stall);
    if (m_valid) begin
      check("pc_o", pc_o, m_pc); check("rd_v_o", rd_v_o, m_rdv); check("rd_adr_o", rd_adr_o, m_rda);
      check("rs1_q", rs1_q, m_r1); check("rs2_q", rs2_q, m_r2);
      check("imm_o", imm_o, m_imm); check("ctrl_o", ctrl_o, m_ctrl);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0); check({tag, "_stall"}, stall_cnt, 0);
    check({tag, "_pc"}, pc_o, 0); check({tag, "_rs1"}, rs1_q, 0); check({tag, "_rs2"}, rs2_q, 0);
    check({tag, "_imm"}, imm_o, 0); check({tag, "_ctrl"}, ctrl_o, 0); check({tag, "_rda"}, rd_adr_o, 0);
  endtask

  initial begin
    idle(); reset = 1'b1;
    step(); step();
    check_zero("rst");
    idle(); in_valid = 1; pc = 32'h100; rs1_v = 1; rs1_adr = 5; rs1_data = 32'h10;
    rs2_v = 1; rs2_adr = 6; rs2_data = 32'hFFFF_FFFF;
    step();
    check("rf_valid", out_valid, 1); check("rf_rs1", rs1_q, 33'h0_0000_0010); check("rf_rs2", rs2_q, 33'h1_FFFF_FFFF);
    idle(); in_valid = 1; rs1_v = 1; rs1_adr = 7; ff_v = 3'b101;
    ff_adr_a[0] = 7; ff_adr_a[2] = 7; ff_data_a[0] = 32'hA; ff_data_a[2] = 32'hB;
    step();
    check("prio_rs1", rs1_q, 33'hA);
    rs1_adr = 0; ff_adr_a[0] = 0; ff_data_a[0] = 32'h55;
    step();
    check("x0_rs1", rs1_q, 0);
    idle(); in_valid = 1; rs2_v = 1; rs2_adr = 9; ff_v[0] = 1; ff_adr_a[0] = 9; ff_rdy = 3'b110;
    repeat (3) begin step(); check("lu_rdy", last_rdy, 0); end
    check("lu_stall", stall_cnt, 3);
    ff_rdy[0] = 1; ff_data_a[0] = 32'h1234;
    step();
    check("lu_valid", out_valid, 1); check("lu_rs2", rs2_q, 33'h1234);
    idle(); in_valid = 1; rs1_v = 1; rs1_adr = 3; rs1_data = 32'h0F; clear = 1;
    rs2_is_imm = 1; imm = 5; ca2 = 1;
    step();
    check("ca2_rs2", rs2_q, 33'h1_FFFF_FFFB); check("clr_rs1", rs1_q, 33'h0_FFFF_FFF0);
    idle(); in_valid = 1; pc = 32'hAAAA_0000; ctrl = 32'h1357;
    step();
    out_ready = 0; pc = 32'hBBBB_0000; ctrl = 32'h2468;
    repeat (2) begin
      step();
      check("bp_rdy", last_rdy, 0); check("bp_valid", out_valid, 1);
      check("bp_pc", pc_o, 32'hAAAA_0000); check("bp_ctrl", ctrl_o, 32'h1357);
    end
    flush = 1;
    step();
    check("fl_rdy", last_rdy, 1); check("fl_valid", out_valid, 0);
    flush = 0; in_valid = 0; out_ready = 1;
    step();
    check("fl_drop", out_valid, 0);
    idle(); in_valid = 1; rs1_v = 1; rs1_adr = 4; ff_v[1] = 1; ff_adr_a[1] = 4; ff_rdy = 3'b101;
    step();
    check("ms_stall", stall_cnt, 4);
    reset = 1;
    step();
    check_zero("ms_rst");
    reset = 0;
    repeat (2000) begin rnd(); step(); end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dec1_fwd_stage.md
Name: dec1_fwd_stage

Overview:
Parametrised second decode stage that selects and qualifies the two operands before they are registered into the execute-stage pipeline register.
- Operands resolve from the register file, from NB_FF forwarding sources, from the immediate or from PC.
- Operands are extended to XLEN+1 bits and can be inverted or two's-complemented.
- Adds what the previous dec1 lacks: valid/ready handshake, back-pressure from EXE, load-use hazard stalls on not-yet-ready forwards, flush, and a saturating stall counter.

Parameters:
XLEN, 32, datapath width
NB_FF, 3, number of forwarding sources; index 0 is the youngest and has the highest priority
CTRL_W, 32, width of opaque sideband control bits (unit, operation, access size, csr, exception flags) carried through unchanged
STALL_CNT_W, 16, width of the hazard-stall counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid_i  in  1  dec0 holds a valid instruction
in_ready_o  out  1  stage accepts the instruction this cycle
pc_i  in  XLEN  instruction PC
rd_v_i  in  1  destination register write enable
rd_adr_i  in  5  destination register address
rs1_v_i  in  1  rs1 read from the register file
rs1_adr_i  in  5  rs1 address
rs1_data_i  in  XLEN  rs1 value from the register file
rs2_v_i  in  1  rs2 read from the register file
rs2_adr_i  in  5  rs2 address
rs2_data_i  in  XLEN  rs2 value from the register file
rs1_is_imm_i  in  1  OR the immediate into op1
rs2_is_imm_i  in  1  OR the immediate into op2
auipc_i  in  1  OR pc_i into op1
imm_i  in  XLEN  immediate
unsign_i  in  1  zero-extend (otherwise sign-extend)
clear_i  in  1  bitwise-invert op1 data bits
ca2_i  in  1  two's-complement op2
ctrl_i  in  CTRL_W  sideband control
ff_v_i  in  NB_FF  forward source i will write rd
ff_adr_i  in  5*NB_FF  forward rd addresses; source i occupies bits [5i+4:5i]
ff_rdy_i  in  NB_FF  forward data valid this cycle
ff_data_i  in  XLEN*NB_FF  forward data
flush_i  in  1  branch/exception flush
out_valid_o  out  1  output register valid
out_ready_i  in  1  EXE accepts output
pc_o  out  XLEN  registered PC
rd_v_o  out  1  registered rd write enable
rd_adr_o  out  5  registered rd address
rs1_q_o  out  XLEN+1  qualified op1
rs2_q_o  out  XLEN+1  qualified op2
imm_o  out  XLEN  registered immediate
ctrl_o  out  CTRL_W  registered sideband
stall_cnt_o  out  STALL_CNT_W  hazard-stall cycle count

Behaviour:
- Reset (reset=1 at a clk edge): all outputs and registers go to 0, including out_valid_o and stall_cnt_o. Reset overrides every other event.
- Match rule: source i matches rsX when ff_v_i[i], ff_adr_i[i]==rsX_adr_i, rsX_adr_i!=0 and rsX_v_i.
  - The selected source is the lowest-index matching source.
  - With no match, the operand comes from rsX_data_i.
  - Address x0 always reads 0 from the register file and never forwards.
- Hazard: hz = a selected source has ff_rdy_i=0, for rs1 or rs2. Lower-index sources never fall back to higher ones.
- op1 data = (rs1_v_i ? sel1 : 0) | (rs1_is_imm_i ? imm_i : 0) | (auipc_i ? pc_i : 0).
  - ext1 = ~unsign_i & op1[XLEN-1].
  - rs1 next = {ext1, clear_i ? ~op1 : op1}; the extension bit is not inverted.
- op2 data = (rs2_v_i ? sel2 : 0) | (rs2_is_imm_i ? imm_i : 0).
  - e2 = {~unsign_i & op2[XLEN-1], op2}.
  - rs2 next = ca2_i ? (~e2 + 1) mod 2^(XLEN+1) : e2.
- Handshake, all combinational:
  - adv = ~out_valid_o | out_ready_i.
  - in_ready_o = flush_i | (adv & ~hz).
  - accept = in_valid_i & in_ready_o & ~flush_i.
- Register update:
  - On accept, all output registers load and out_valid_o goes to 1 the next cycle; latency is 1 cycle.
  - Else if out_ready_i or flush_i, out_valid_o goes to 0.
  - Otherwise out_valid_o and all output registers hold.
- Flush: flush_i=1 clears out_valid_o the next cycle and discards the input (in_ready_o=1, nothing loaded). Flush has priority over hz and back-pressure.
- Stall counter: increments on each cycle with in_valid_i & hz & ~flush_i & adv. It saturates at all-ones, and only reset clears it.
- Output data registers need not be cleared when out_valid_o=0.
- Back-pressure: out_valid_o=1 and out_ready_i=0 gives in_ready_o=0 (unless flush_i), and outputs stay stable.

Test Plan:
- RF path: rs1_adr=5, rs1_data=0x10, rs2_adr=6, rs2_data=0xFFFFFFFF, unsign=0, no matches, out_ready=1 -> next cycle out_valid=1, rs1_q=0x0_00000010, rs2_q=0x1_FFFFFFFF.
- Priority: sources 0 and 2 both match rs1=7, data 0xA/0xB, both ready -> rs1_q=0xA. With adr=0 and a matching forward of 0x55 -> rs1_q=0.
- Load-use: source 0 matches rs2 with ff_rdy=0 for 3 cycles, then 1 with 0x1234 -> in_ready_o=0 for 3 cycles, stall_cnt_o=3, then rs2_q=0x1234.
- ca2/clear: op2=5, ca2=1, unsign=0 -> rs2_q=0x1_FFFFFFFB. op1=0x0F, clear=1 -> rs1_q=0x0_FFFFFFF0.
- Back-pressure then flush: out_valid=1, out_ready=0 for 2 cycles -> outputs held, in_ready_o=0. Then flush_i=1 with in_valid=1 -> out_valid=0 the next cycle and the input is dropped.
- Reset mid-stall: hz active and stall_cnt=4, assert reset -> next cycle out_valid=0, stall_cnt=0, all outputs 0.
